// File: rtl/c880_pkg.sv
// Shared types and constants for the c880 ALU/flag block.
// Opcode decoding uses op[2:0]; op[MASK_BIT] gates the result mask.
package c880_pkg;

   localparam int MASK_BIT = 3;

   typedef enum logic [2:0] {
      ADD   = 3'd0,
      SUB   = 3'd1,
      AND   = 3'd2,
      OR    = 3'd3,
      XOR   = 3'd4,
      NOTA  = 3'd5,
      PASSA = 3'd6,
      PASSB = 3'd7
   } opcode_e;

   // Only the adder ops produce a carry or a signed overflow.
   function automatic logic is_arith(opcode_e op);
      return (op == ADD) || (op == SUB);
   endfunction

endpackage

// File: rtl/c880_if.sv
// Operand/result bundle between the c880 top level and its 8-bit ALU.
// master drives operands and reads results; slave is the ALU side.
interface c880_if;
   logic [7:0] a;
   logic [7:0] b;
   logic [7:0] m;
   logic [3:0] op;
   logic       cin;
   logic [7:0] r;
   logic       k;
   logic       ovf;
   logic       zero;

   modport master (output a, b, m, op, cin, input  r, k, ovf, zero);
   modport slave  (input  a, b, m, op, cin, output r, k, ovf, zero);
endinterface

// File: rtl/c880_alu8.sv
// Combinational 8-bit ALU: add/sub with carry and signed overflow, logic ops,
// optional result mask and zero flag. No storage, zero latency.
module c880_alu8
   import c880_pkg::*;
(
   c880_if.slave bus
);

   opcode_e    op_sel;
   logic [7:0] b_eff;
   logic [8:0] sum;
   logic [7:0] core_r;
   logic       core_k;
   logic       core_ovf;
   logic [7:0] masked_r;

   always_comb begin
      op_sel   = opcode_e'(bus.op[2:0]);
      b_eff    = (op_sel == SUB) ? ~bus.b : bus.b;
      sum      = {1'b0, bus.a} + {1'b0, b_eff} + {8'd0, bus.cin};
      core_r   = sum[7:0];
      core_k   = 1'b0;
      core_ovf = 1'b0;
      case (op_sel)
         ADD, SUB: begin
            core_r   = sum[7:0];
            core_k   = sum[8];
            core_ovf = (bus.a[7] == b_eff[7]) && (sum[7] != bus.a[7]);
         end
         AND:   core_r = bus.a & bus.b;
         OR:    core_r = bus.a | bus.b;
         XOR:   core_r = bus.a ^ bus.b;
         NOTA:  core_r = ~bus.a;
         PASSA: core_r = bus.a;
         PASSB: core_r = bus.b;
      endcase
      if (!is_arith(op_sel)) begin
         core_k   = 1'b0;
         core_ovf = 1'b0;
      end
   end

   // The mask only shapes R and the zero flag; carry and overflow see the raw sum.
   assign masked_r = bus.op[MASK_BIT] ? (core_r & bus.m) : core_r;

   assign bus.r    = masked_r;
   assign bus.k    = core_k;
   assign bus.ovf  = core_ovf;
   assign bus.zero = (masked_r == 8'h00);

endmodule

// File: rtl/c880.sv
// c880 top: decode/select/parity flags plus 8-bit ALU, all 26 outputs registered.
// One-cycle latency, loads every edge; synchronous active-high reset clears all.
module c880
   import c880_pkg::*;
(
   input  logic clk,
   input  logic rst,
   input  logic N1,
   input  logic N8,
   input  logic N13,
   input  logic N17,
   input  logic N26,
   input  logic N29,
   input  logic N36,
   input  logic N42,
   input  logic N51,
   input  logic N55,
   input  logic N59,
   input  logic N68,
   input  logic N72,
   input  logic N73,
   input  logic N74,
   input  logic N75,
   input  logic N80,
   input  logic N85,
   input  logic N86,
   input  logic N87,
   input  logic N88,
   input  logic N89,
   input  logic N90,
   input  logic N91,
   input  logic N96,
   input  logic N101,
   input  logic N106,
   input  logic N111,
   input  logic N116,
   input  logic N121,
   input  logic N126,
   input  logic N130,
   input  logic N135,
   input  logic N138,
   input  logic N143,
   input  logic N146,
   input  logic N149,
   input  logic N152,
   input  logic N153,
   input  logic N156,
   input  logic N159,
   input  logic N165,
   input  logic N171,
   input  logic N177,
   input  logic N183,
   input  logic N189,
   input  logic N195,
   input  logic N201,
   input  logic N207,
   input  logic N210,
   input  logic N219,
   input  logic N228,
   input  logic N237,
   input  logic N246,
   input  logic N255,
   input  logic N259,
   input  logic N260,
   input  logic N261,
   input  logic N267,
   input  logic N268,
   output logic N388,
   output logic N389,
   output logic N390,
   output logic N391,
   output logic N418,
   output logic N419,
   output logic N420,
   output logic N421,
   output logic N422,
   output logic N423,
   output logic N446,
   output logic N447,
   output logic N448,
   output logic N449,
   output logic N450,
   output logic N767,
   output logic N768,
   output logic N850,
   output logic N863,
   output logic N864,
   output logic N865,
   output logic N866,
   output logic N874,
   output logic N878,
   output logic N879,
   output logic N880
);

   logic [15:0] dec_in;
   logic [7:0]  sel_in;
   logic [6:0]  chk_in;

   logic [3:0]  dec_d,  dec_q;
   logic [5:0]  sel_d,  sel_q;
   logic [4:0]  par_d,  par_q;
   logic [7:0]  res_d,  res_q;
   logic        zero_d, zero_q;
   logic        ovf_d,  ovf_q;
   logic        cout_d, cout_q;

   assign dec_in = {N75, N74, N73, N72, N68, N59, N55, N51,
                    N42, N36, N29, N26, N17, N13, N8,  N1};
   assign sel_in = {N91, N90, N89, N88, N87, N86, N85, N80};
   assign chk_in = {N267, N261, N260, N259, N255, N246, N237};

   c880_if alu_bus ();

   assign alu_bus.a   = {N130, N126, N121, N116, N111, N106, N101, N96};
   assign alu_bus.m   = {N156, N153, N152, N149, N146, N143, N138, N135};
   assign alu_bus.b   = {N201, N195, N189, N183, N177, N171, N165, N159};
   assign alu_bus.op  = {N228, N219, N210, N207};
   assign alu_bus.cin = N268;

   c880_alu8 u_alu (
      .bus (alu_bus.slave)
   );

   always_comb begin
      for (int i = 0; i < 4; i++) begin
         dec_d[i] = &dec_in[4*i +: 4];
         sel_d[i] = ~|sel_in[2*i +: 2];
      end
      // The NAND select flags look at the decode values being loaded this edge.
      sel_d[4] = ~(dec_d[0] & dec_d[1]);
      sel_d[5] = ~(dec_d[2] & dec_d[3]);

      par_d[0] = ^alu_bus.a;
      par_d[1] = ^alu_bus.b;
      par_d[2] = ^alu_bus.m;
      par_d[3] = ~(par_d[0] ^ par_d[1]);
      par_d[4] = ^chk_in;

      res_d  = alu_bus.r;
      zero_d = alu_bus.zero;
      ovf_d  = alu_bus.ovf;
      cout_d = alu_bus.k;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         dec_q  <= '0;
         sel_q  <= '0;
         par_q  <= '0;
         res_q  <= '0;
         zero_q <= 1'b0;
         ovf_q  <= 1'b0;
         cout_q <= 1'b0;
      end else begin
         dec_q  <= dec_d;
         sel_q  <= sel_d;
         par_q  <= par_d;
         res_q  <= res_d;
         zero_q <= zero_d;
         ovf_q  <= ovf_d;
         cout_q <= cout_d;
      end
   end

   assign {N391, N390, N389, N388}             = dec_q;
   assign {N423, N422, N421, N420, N419, N418} = sel_q;
   assign {N450, N449, N448, N447, N446}       = par_q;
   assign N767 = zero_q;
   assign N768 = ovf_q;
   assign N850 = cout_q;
   assign {N880, N879, N878, N874, N866, N865, N864, N863} = res_q;

endmodule

// File: tb/tb_c880.sv
// Bench for c880: fixed vector table, reset sequences, and random back-to-back
// traffic compared against an arithmetic reference model.
module tb_c880;

   typedef struct packed {
      logic [15:0] d;
      logic [7:0]  s;
      logic [7:0]  a;
      logic [7:0]  m;
      logic [7:0]  b;
      logic [3:0]  op;
      logic [6:0]  c;
      logic        cin;
   } vec_in_t;

   typedef struct {
      vec_in_t     in;
      logic [25:0] exp;
   } vec_t;

   logic        clk;
   logic        rst;
   logic [15:0] d_i;
   logic [7:0]  s_i;
   logic [6:0]  c_i;

   logic [7:0]  r_o;
   logic [3:0]  dec_o;
   logic [5:0]  sel_o;
   logic [4:0]  par_o;
   logic        z_o, ov_o, co_o;
   logic [25:0] obs;

   int n_vec;
   int n_err;
   vec_t tbl[11];

   c880_if tb_bus ();

   assign tb_bus.r    = r_o;
   assign tb_bus.k    = co_o;
   assign tb_bus.ovf  = ov_o;
   assign tb_bus.zero = z_o;
   assign obs = {tb_bus.r, tb_bus.k, tb_bus.ovf, tb_bus.zero, par_o, sel_o, dec_o};

   c880 dut (
      .clk(clk), .rst(rst),
      .N1(d_i[0]),   .N8(d_i[1]),   .N13(d_i[2]),  .N17(d_i[3]),
      .N26(d_i[4]),  .N29(d_i[5]),  .N36(d_i[6]),  .N42(d_i[7]),
      .N51(d_i[8]),  .N55(d_i[9]),  .N59(d_i[10]), .N68(d_i[11]),
      .N72(d_i[12]), .N73(d_i[13]), .N74(d_i[14]), .N75(d_i[15]),
      .N80(s_i[0]),  .N85(s_i[1]),  .N86(s_i[2]),  .N87(s_i[3]),
      .N88(s_i[4]),  .N89(s_i[5]),  .N90(s_i[6]),  .N91(s_i[7]),
      .N96(tb_bus.a[0]),  .N101(tb_bus.a[1]), .N106(tb_bus.a[2]), .N111(tb_bus.a[3]),
      .N116(tb_bus.a[4]), .N121(tb_bus.a[5]), .N126(tb_bus.a[6]), .N130(tb_bus.a[7]),
      .N135(tb_bus.m[0]), .N138(tb_bus.m[1]), .N143(tb_bus.m[2]), .N146(tb_bus.m[3]),
      .N149(tb_bus.m[4]), .N152(tb_bus.m[5]), .N153(tb_bus.m[6]), .N156(tb_bus.m[7]),
      .N159(tb_bus.b[0]), .N165(tb_bus.b[1]), .N171(tb_bus.b[2]), .N177(tb_bus.b[3]),
      .N183(tb_bus.b[4]), .N189(tb_bus.b[5]), .N195(tb_bus.b[6]), .N201(tb_bus.b[7]),
      .N207(tb_bus.op[0]), .N210(tb_bus.op[1]), .N219(tb_bus.op[2]), .N228(tb_bus.op[3]),
      .N237(c_i[0]), .N246(c_i[1]), .N255(c_i[2]), .N259(c_i[3]),
      .N260(c_i[4]), .N261(c_i[5]), .N267(c_i[6]), .N268(tb_bus.cin),
      .N388(dec_o[0]), .N389(dec_o[1]), .N390(dec_o[2]), .N391(dec_o[3]),
      .N418(sel_o[0]), .N419(sel_o[1]), .N420(sel_o[2]), .N421(sel_o[3]),
      .N422(sel_o[4]), .N423(sel_o[5]),
      .N446(par_o[0]), .N447(par_o[1]), .N448(par_o[2]), .N449(par_o[3]), .N450(par_o[4]),
      .N767(z_o), .N768(ov_o), .N850(co_o),
      .N863(r_o[0]), .N864(r_o[1]), .N865(r_o[2]), .N866(r_o[3]),
      .N874(r_o[4]), .N878(r_o[5]), .N879(r_o[6]), .N880(r_o[7])
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic vec_in_t mk(logic [15:0] d, logic [7:0] s, logic [7:0] a,
                                  logic [7:0] m, logic [7:0] b, logic [3:0] op,
                                  logic [6:0] c, logic cin);
      vec_in_t v;
      v.d = d; v.s = s; v.a = a; v.m = m; v.b = b; v.op = op; v.c = c; v.cin = cin;
      return v;
   endfunction

   // Expected-output packing: {R, carry, overflow, zero, parity[4:0], select[5:0], decode[3:0]}
   function automatic logic [25:0] pk(logic [7:0] r, logic co, logic ov, logic z,
                                      logic [4:0] par, logic [5:0] sel, logic [3:0] dec);
      return {r, co, ov, z, par, sel, dec};
   endfunction

   // Reference model: integer arithmetic on unsigned and signed views of the operands.
   function automatic logic [25:0] model(vec_in_t v);
      int ua, ub, sa, sb, full, ssum, r;
      logic co, ov;
      logic [3:0] dec;
      logic [5:0] sel;
      logic [4:0] par;
      ua = int'(v.a);
      ub = int'(v.b);
      sa = int'($signed(v.a));
      sb = int'($signed(v.b));
      full = 0;
      co = 1'b0;
      ov = 1'b0;
      case (v.op[2:0])
         3'd0: begin
            full = ua + ub + int'(v.cin);
            ssum = sa + sb + int'(v.cin);
            co = (full > 255);
            ov = (ssum > 127) || (ssum < -128);
         end
         3'd1: begin
            full = ua + (255 - ub) + int'(v.cin);
            ssum = sa + (-sb - 1) + int'(v.cin);
            co = (full > 255);
            ov = (ssum > 127) || (ssum < -128);
         end
         3'd2: full = int'(v.a & v.b);
         3'd3: full = int'(v.a | v.b);
         3'd4: full = int'(v.a ^ v.b);
         3'd5: full = 255 - ua;
         3'd6: full = ua;
         default: full = ub;
      endcase
      r = full % 256;
      if (v.op[3]) r = r & int'(v.m);
      for (int i = 0; i < 4; i++) begin
         dec[i] = (v.d[4*i +: 4] == 4'hF);
         sel[i] = (v.s[2*i +: 2] == 2'b00);
      end
      sel[4] = !(dec[0] && dec[1]);
      sel[5] = !(dec[2] && dec[3]);
      par[0] = ^v.a;
      par[1] = ^v.b;
      par[2] = ^v.m;
      par[3] = (par[0] == par[1]);
      par[4] = ^v.c;
      return {8'(r), co, ov, (r == 0), par, sel, dec};
   endfunction

   function automatic vec_in_t rnd_vec();
      vec_in_t v;
      v.d = 16'($urandom);
      v.s = 8'($urandom);
      for (int i = 0; i < 4; i++) begin
         if ($urandom_range(1, 0) == 1) v.d[4*i +: 4] = 4'hF;
         if ($urandom_range(1, 0) == 1) v.s[2*i +: 2] = 2'b00;
      end
      v.a   = 8'($urandom);
      v.m   = 8'($urandom);
      v.b   = 8'($urandom);
      v.op  = 4'($urandom);
      v.c   = 7'($urandom);
      v.cin = 1'($urandom);
      if ($urandom_range(7, 0) == 0) v.a = 8'hFF;
      if ($urandom_range(7, 0) == 0) v.b = v.a;
      return v;
   endfunction

   task automatic drive(vec_in_t v);
      d_i = v.d;
      s_i = v.s;
      c_i = v.c;
      tb_bus.a   = v.a;
      tb_bus.m   = v.m;
      tb_bus.b   = v.b;
      tb_bus.op  = v.op;
      tb_bus.cin = v.cin;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(string name, logic [25:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %b required %b", name, obs, exp);
      end
   endtask

   initial begin
      vec_in_t v;
      logic [25:0] exp;
      n_vec = 0;
      n_err = 0;

      tbl[0]  = '{mk(16'h0000, 8'h00, 8'hFF, 8'h00, 8'h01, 4'b0000, 7'h00, 1'b0),
                  pk(8'h00, 1'b1, 1'b0, 1'b1, 5'b00010, 6'b111111, 4'b0000)};
      tbl[1]  = '{mk(16'h0000, 8'h00, 8'h7F, 8'h00, 8'h01, 4'b0000, 7'h00, 1'b0),
                  pk(8'h80, 1'b0, 1'b1, 1'b0, 5'b01011, 6'b111111, 4'b0000)};
      tbl[2]  = '{mk(16'h0000, 8'h00, 8'h10, 8'h0F, 8'h01, 4'b1001, 7'h00, 1'b1),
                  pk(8'h0F, 1'b1, 1'b0, 1'b0, 5'b01011, 6'b111111, 4'b0000)};
      tbl[3]  = '{mk(16'hFFFF, 8'h00, 8'h03, 8'h07, 8'h01, 4'b0000, 7'h01, 1'b0),
                  pk(8'h04, 1'b0, 1'b0, 1'b0, 5'b10110, 6'b001111, 4'b1111)};
      tbl[4]  = '{mk(16'h000F, 8'h03, 8'hAA, 8'h3C, 8'hF0, 4'b1111, 7'h7F, 1'b0),
                  pk(8'h30, 1'b0, 1'b0, 1'b0, 5'b11000, 6'b111110, 4'b0001)};
      tbl[5]  = '{mk(16'h0000, 8'hFF, 8'hFF, 8'hFF, 8'h00, 4'b0101, 7'h00, 1'b0),
                  pk(8'h00, 1'b0, 1'b0, 1'b1, 5'b01000, 6'b110000, 4'b0000)};
      tbl[6]  = '{mk(16'h0000, 8'h00, 8'h80, 8'h00, 8'h01, 4'b0001, 7'h00, 1'b1),
                  pk(8'h7F, 1'b1, 1'b1, 1'b0, 5'b01011, 6'b111111, 4'b0000)};
      tbl[7]  = '{mk(16'h0000, 8'h00, 8'hCC, 8'h00, 8'hAA, 4'b0010, 7'h00, 1'b1),
                  pk(8'h88, 1'b0, 1'b0, 1'b0, 5'b01000, 6'b111111, 4'b0000)};
      tbl[8]  = '{mk(16'h0000, 8'h00, 8'h0F, 8'h81, 8'hF0, 4'b1011, 7'h00, 1'b0),
                  pk(8'h81, 1'b0, 1'b0, 1'b0, 5'b01000, 6'b111111, 4'b0000)};
      tbl[9]  = '{mk(16'h0000, 8'h00, 8'h5A, 8'hFF, 8'h5A, 4'b1100, 7'h00, 1'b0),
                  pk(8'h00, 1'b0, 1'b0, 1'b1, 5'b01000, 6'b111111, 4'b0000)};
      tbl[10] = '{mk(16'h0000, 8'h00, 8'h01, 8'h00, 8'h00, 4'b0110, 7'h00, 1'b1),
                  pk(8'h01, 1'b0, 1'b0, 1'b0, 5'b00001, 6'b111111, 4'b0000)};

      // Reset with arbitrary inputs clears every output.
      rst = 1'b1;
      drive(rnd_vec());
      tick();
      check("reset", 26'd0);
      drive(tbl[3].in);
      tick();
      check("reset_hold", 26'd0);

      // First edge after deassertion already loads live data (table entry 0).
      rst = 1'b0;
      for (int i = 0; i < 11; i++) begin
         drive(tbl[i].in);
         tick();
         check($sformatf("table%0d", i), tbl[i].exp);
      end

      // Reset asserted mid-stream discards the pending result, then recovers at once.
      drive(tbl[3].in);
      rst = 1'b1;
      tick();
      check("rst_midstream", 26'd0);
      rst = 1'b0;
      tick();
      check("rst_recover", tbl[3].exp);

      // Back-to-back random traffic with occasional resets.
      for (int n = 0; n < 400; n++) begin
         v = rnd_vec();
         rst = ($urandom_range(15, 0) == 0);
         exp = rst ? 26'd0 : model(v);
         drive(v);
         tick();
         check($sformatf("random%0d", n), exp);
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
